// File: rtl/glb_read.sv
// Global-buffer read port: receives a flushed burst of up to 2048 16-bit words into a local buffer.
// Optional random back-pressure on ready is enabled by defining GLB_READ_BACKPRESSURE_EN.
module glb_read #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [11:0]       tx_size,
  input  logic              flush,
  input  logic [DATA_W:0]   data,
  input  logic              valid,
  output logic              ready,
  output logic              done,
  output logic [11:0]       count,
  input  logic [10:0]       rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [11:0] DEPTH = 12'd2048;

  typedef enum logic [1:0] {IDLE, FLUSH, RECV, DONE} state_t;

  state_t            state, state_nxt;
  logic [11:0]       count_nxt;
  logic [11:0]       tx_lat, tx_lat_nxt;
  logic              hs, wr_en;
  logic [DATA_W-1:0] buffer [2048];

  function automatic logic [11:0] clamp_size(input logic [11:0] s);
    return (s > DEPTH) ? DEPTH : s;
  endfunction

  assign hs = valid & ready;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    tx_lat_nxt = tx_lat;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (enable && flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (!flush) begin
          tx_lat_nxt = clamp_size(tx_size);
          count_nxt  = '0;
          state_nxt  = (clamp_size(tx_size) == 12'd0) ? DONE : RECV;
        end
      end
      RECV: begin
        // An abort wins over a word presented in the same cycle.
        if (flush) begin
          state_nxt = FLUSH;
        end else if (hs) begin
          if (data[DATA_W]) begin
            state_nxt = DONE;
          end else begin
            wr_en = (count < DEPTH);
            if (count < DEPTH) count_nxt = count + 12'd1;
            if (count + 12'd1 == tx_lat) state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (flush) state_nxt = FLUSH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      tx_lat <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      tx_lat <= tx_lat_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buffer[count[10:0]] <= data[DATA_W-1:0];
  end

  assign rd_data = buffer[rd_addr];

  // done is forced low while reset is held, even in IDLE with enable low.
  assign done = rst_n & ((state == DONE) | ((state == IDLE) & ~enable));

`ifdef GLB_READ_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (state == RECV) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign ready = (state == RECV) & lfsr[0];
`else
  assign ready = (state == RECV);
`endif

endmodule
